// File: rtl/sm4_pkg.sv
// Shared SM4 constants and the linear transform L used by the round datapath.
package sm4_pkg;

    localparam int ROUNDS  = 32;
    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 6;
    localparam int IDX_W   = 5;

    // Rotate amounts of the encryption linear transform L.
    localparam int ROT_A = 2;
    localparam int ROT_B = 10;
    localparam int ROT_C = 18;
    localparam int ROT_D = 24;

    // Last counter value that still performs a round on the state register.
    localparam int LAST_ROUND = ROUNDS - 1;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] l_transform(input logic [WORD_W-1:0] x);
        return x ^ rotl(x, ROT_A) ^ rotl(x, ROT_B) ^ rotl(x, ROT_C) ^ rotl(x, ROT_D);
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box as a 256-entry combinational lookup table.
module sm4_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX_ROM [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign o_byte = SBOX_ROM[i_byte];

endmodule

// File: rtl/sm4_round_datapath.sv
// SM4 round datapath: one round per clock, sequenced by an external controller's
// counter. Optional decryption (reversed round-key order) is enabled by defining
// the macro SM4_DECRYPT_EN, which adds the input port mode.
module sm4_round_datapath
    import sm4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 valid_in,
    input  logic [CNT_W-1:0]     counter,
    input  logic                 save_data,
    input  logic [BLOCK_W-1:0]   data_in,
    input  logic [WORD_W-1:0]    rk_in,
`ifdef SM4_DECRYPT_EN
    input  logic                 mode,
`endif
    output logic [IDX_W-1:0]     rk_idx,
    output logic [BLOCK_W-1:0]   data_out,
    output logic                 data_valid
);

    logic [BLOCK_W-1:0] r_state;
    logic               r_busy;
    logic [BLOCK_W-1:0] r_data_out;
    logic               r_data_valid;

    logic               w_load;
    logic               w_round;
    logic               w_save;
    logic [BLOCK_W-1:0] w_src;
    logic [WORD_W-1:0]  w_a, w_b, w_c, w_d;
    logic [WORD_W-1:0]  w_sin;
    logic [WORD_W-1:0]  w_tau;
    logic [WORD_W-1:0]  w_f;

    assign w_load  = valid_in && (counter == '0);
    assign w_round = valid_in && r_busy && (counter >= CNT_W'(1)) && (counter <= CNT_W'(LAST_ROUND));
    assign w_save  = save_data && r_busy;

    // Round 0 works directly on the incoming block so it costs no extra cycle.
    assign w_src = w_load ? data_in : r_state;
    assign {w_a, w_b, w_c, w_d} = w_src;
    assign w_sin = w_b ^ w_c ^ w_d ^ rk_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            sm4_sbox u_sbox (
                .i_byte (w_sin[gi*8 +: 8]),
                .o_byte (w_tau[gi*8 +: 8])
            );
        end
    endgenerate

    assign w_f = w_a ^ l_transform(w_tau);

`ifdef SM4_DECRYPT_EN
    logic r_mode;
    logic w_mode;

    // On the load cycle the latched mode is not yet valid, so use the port directly.
    assign w_mode = (counter == '0) ? mode : r_mode;
    assign rk_idx = w_mode ? (IDX_W'(LAST_ROUND) - counter[IDX_W-1:0]) : counter[IDX_W-1:0];

    // Latch the direction at load time and hold it for the whole operation.
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_mode <= 1'b0;
        end else if (w_load && !w_save) begin
            r_mode <= mode;
        end
    end
`else
    assign rk_idx = counter[IDX_W-1:0];
`endif

    // State, busy flag and result registers; save wins over abort, load and round.
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state      <= '0;
            r_busy       <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_save) begin
                r_data_out   <= {r_state[31:0], r_state[63:32], r_state[95:64], r_state[127:96]};
                r_data_valid <= 1'b1;
                r_busy       <= 1'b0;
            end else if (!valid_in) begin
                r_busy <= 1'b0;
            end else if (w_load) begin
                r_state <= {w_b, w_c, w_d, w_f};
                r_busy  <= 1'b1;
            end else if (w_round) begin
                r_state <= {w_b, w_c, w_d, w_f};
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_sm4_round_datapath.sv
// Self-checking bench for sm4_round_datapath: a controller model drives the
// counter/save_data sequence, a key store answers rk_idx, and a reference SM4
// model fills a scoreboard of expected results. Define SM4_DECRYPT_EN to also
// exercise the decrypt path.
module tb_sm4_round_datapath;

    logic         clk = 1'b0;
    logic         rest;
    logic         valid_in;
    logic [5:0]   counter;
    logic         save_data;
    logic [127:0] data_in;
    logic [31:0]  rk_in;
    logic [4:0]   rk_idx;
    logic [127:0] data_out;
    logic         data_valid;
`ifdef SM4_DECRYPT_EN
    logic         mode;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    int           obs_cyc_q[$];
    logic [31:0]  rk_tbl [32];

    localparam logic [127:0] VEC_PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VEC_CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] VEC_KEY = 128'h0123456789abcdeffedcba9876543210;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    sm4_round_datapath dut (
        .clk        (clk),
        .rest       (rest),
        .valid_in   (valid_in),
        .counter    (counter),
        .save_data  (save_data),
        .data_in    (data_in),
        .rk_in      (rk_in),
`ifdef SM4_DECRYPT_EN
        .mode       (mode),
`endif
        .rk_idx     (rk_idx),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    // Key store: answers the requested index in the same cycle.
    always_comb rk_in = rk_tbl[rk_idx];

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] x);
        return {TB_SBOX[x[31:24]], TB_SBOX[x[23:16]], TB_SBOX[x[15:8]], TB_SBOX[x[7:0]]};
    endfunction

    function automatic logic [127:0] sm4_model(input logic [127:0] blk, input bit dec);
        logic [31:0] x0, x1, x2, x3, t, k;
        {x0, x1, x2, x3} = blk;
        for (int i = 0; i < 32; i++) begin
            k  = dec ? rk_tbl[31 - i] : rk_tbl[i];
            t  = tau(x1 ^ x2 ^ x3 ^ k);
            t  = x0 ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
            x0 = x1; x1 = x2; x2 = x3; x3 = t;
        end
        return {x3, x2, x1, x0};
    endfunction

    task automatic init_keys(input logic [127:0] mk);
        logic [31:0] kw [36];
        logic [31:0] fk [4];
        logic [31:0] ck, t;
        logic [7:0]  cb;
        fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
        for (int j = 0; j < 4; j++) kw[j] = mk[127 - 32*j -: 32] ^ fk[j];
        for (int i = 0; i < 32; i++) begin
            ck = '0;
            for (int j = 0; j < 4; j++) begin
                cb = 8'(((4*i + j) * 7) % 256);
                ck = {ck[23:0], cb};
            end
            t = tau(kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck);
            kw[i+4]   = kw[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            rk_tbl[i] = kw[i+4];
        end
    endtask

    // ---------------- driving helpers ----------------
    // One clock; outputs sampled 1 time unit after the edge, pulses logged.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (data_valid === 1'b1) begin
            obs_q.push_back(data_out);
            obs_cyc_q.push_back(cyc);
        end
    endtask

    task automatic go_idle();
        valid_in  = 1'b0;
        counter   = 6'd0;
        save_data = 1'b0;
        rest      = 1'b1;
    endtask

    // Controller model: counter 0..32 with save_data at 32, optional early drop,
    // reset at a given counter, or extra held counts past 32.
    task automatic run_op(input logic [127:0] din, input bit dec, input int drop_at,
                          input int rst_at, input int extra, output int start_cyc);
        bit          stopped;
        logic [4:0]  exp_idx;
        stopped   = 1'b0;
        start_cyc = cyc;
        data_in   = din;
        for (int c = 0; c <= 32 && !stopped; c++) begin
            if (c == drop_at) begin
                go_idle();
                step();
                stopped = 1'b1;
            end else begin
                valid_in  = 1'b1;
                counter   = c[5:0];
                save_data = (c == 32);
                rest      = (c == rst_at) ? 1'b0 : 1'b1;
`ifdef SM4_DECRYPT_EN
                // Flip the port after the load cycle: the latched direction must win.
                mode = (c == 0) ? dec : ~dec;
`endif
                #1;
                if (c < 32) begin
                    exp_idx = dec ? 5'(31 - c) : 5'(c);
                    checks++;
                    if (rk_idx !== exp_idx) begin
                        errors++;
                        $display("FAIL rk_idx counter=%0d got %0d want %0d", c, rk_idx, exp_idx);
                    end
                end
                step();
                if (c == rst_at) stopped = 1'b1;
            end
        end
        if (!stopped) begin
            for (int c = 33; c < 33 + extra; c++) begin
                valid_in  = 1'b1;
                counter   = c[5:0];
                save_data = 1'b0;
                step();
            end
        end
        go_idle();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        go_idle();
        rest = 1'b0;
        data_in = '0;
        repeat (3) step();
        checks++;
        if (data_out !== 128'd0) begin
            errors++; $display("FAIL reset_data_out got %h want 0", data_out);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_data_valid got %b want 0", data_valid);
        end
        checks++;
        if (rk_idx !== 5'd0) begin
            errors++; $display("FAIL reset_rk_idx got %0d want 0", rk_idx);
        end
        rest = 1'b1;
        step();
        obs_q.delete(); obs_cyc_q.delete();
        $display("test_reset: done");
    endtask

    task automatic test_vector();
        int st;
        exp_q.push_back(VEC_CT);
        run_op(VEC_PT, 1'b0, -1, -1, 0, st);
        step();
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL vector_pulses got %0d want 1", obs_q.size());
        end else begin
            logic [127:0] e, o;
            int oc;
            e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL vector_data got %h want %h", o, e);
            end
            checks++;
            if (oc - st != 33) begin
                errors++; $display("FAIL vector_latency got %0d want 33 edges (34th cycle)", oc - st);
            end
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL vector_pulse_width data_valid got %b want 0", data_valid);
        end
        exp_q.delete();
        $display("test_vector: pt=%h ct=%h", VEC_PT, data_out);
    endtask

    task automatic test_abort();
        int st;
        logic [127:0] d, e, o;
        d = {$urandom, $urandom, $urandom, $urandom};
        run_op(d, 1'b0, 17, -1, 0, st);
        repeat (3) step();
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL abort_pulses got %0d want 0", obs_q.size());
        end
        checks++;
        if (data_out !== VEC_CT) begin
            errors++; $display("FAIL abort_data_out got %h want %h", data_out, VEC_CT);
        end
        obs_q.delete(); obs_cyc_q.delete();
        // Restart right away with a fresh block.
        d = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(sm4_model(d, 1'b0));
        run_op(d, 1'b0, -1, -1, 0, st);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL abort_restart_pulses got %0d want 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL abort_restart_data got %h want %h", o, e);
            end
        end
        exp_q.delete();
        $display("test_abort: restart result %h", data_out);
    endtask

    task automatic test_reset_mid();
        int st;
        logic [127:0] d, e, o;
        d = {$urandom, $urandom, $urandom, $urandom};
        run_op(d, 1'b0, -1, 20, 0, st);
        checks++;
        if (data_out !== 128'd0 || data_valid !== 1'b0 || rk_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid outputs got out=%h dv=%b idx=%0d want all 0", data_out, data_valid, rk_idx);
        end
        // Reset coincident with save_data: no pulse, result discarded.
        d = {$urandom, $urandom, $urandom, $urandom};
        run_op(d, 1'b0, -1, 32, 0, st);
        checks++;
        if (data_valid !== 1'b0 || data_out !== 128'd0) begin
            errors++; $display("FAIL reset_at_save got dv=%b out=%h want dv=0 out=0", data_valid, data_out);
        end
        step();
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL reset_at_save_pulses got %0d want 0", obs_q.size());
        end
        obs_q.delete(); obs_cyc_q.delete();
        // Clean start after reset.
        d = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(sm4_model(d, 1'b0));
        run_op(d, 1'b0, -1, -1, 0, st);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL reset_clean_pulses got %0d want 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL reset_clean_data got %h want %h", o, e);
            end
        end
        exp_q.delete();
        $display("test_reset_mid: clean result %h", data_out);
    endtask

    task automatic test_hold_past();
        int st;
        logic [127:0] d, e, o;
        d = {$urandom, $urandom, $urandom, $urandom};
        e = sm4_model(d, 1'b0);
        exp_q.push_back(e);
        run_op(d, 1'b0, -1, -1, 8, st);
        repeat (2) step();
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL hold_pulses got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            void'(exp_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL hold_data got %h want %h", o, e);
            end
        end
        checks++;
        if (data_out !== e) begin
            errors++; $display("FAIL hold_stable got %h want %h", data_out, e);
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        $display("test_hold_past: result %h", data_out);
    endtask

    task automatic test_back_to_back();
        int st;
        logic [127:0] d1, d2, e, o;
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(sm4_model(d1, 1'b0));
        exp_q.push_back(sm4_model(d2, 1'b0));
        run_op(d1, 1'b0, -1, -1, 0, st);
        step();
        run_op(d2, 1'b0, -1, -1, 0, st);
        step();
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL b2b_pulses got %0d want 2", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL b2b_data got %h want %h", o, e);
            end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        $display("test_back_to_back: last result %h", data_out);
    endtask

`ifdef SM4_DECRYPT_EN
    task automatic test_decrypt();
        int st;
        logic [127:0] e, o;
        exp_q.push_back(VEC_PT);
        run_op(VEC_CT, 1'b1, -1, -1, 0, st);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL decrypt_pulses got %0d want 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL decrypt_data got %h want %h", o, e);
            end
        end
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        $display("test_decrypt: result %h", data_out);
    endtask
`endif

    initial begin
`ifdef SM4_DECRYPT_EN
        mode = 1'b0;
`endif
        go_idle();
        data_in = '0;
        init_keys(VEC_KEY);
        test_reset();
        test_vector();
        test_abort();
        test_reset_mid();
        test_hold_past();
        test_back_to_back();
`ifdef SM4_DECRYPT_EN
        test_decrypt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm4_round_datapath.md
SM4_ROUND_DATAPATH -- requirements
Module: sm4_round_datapath

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rest  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port valid_in  input  1  operation request, same signal as driven into the SM4 controller.
REQ-004 SHALL have port counter  input  6  round counter from the SM4 controller, range 0..32.
REQ-005 SHALL have port save_data  input  1  controller strobe, high when counter==32.
REQ-006 SHALL have port data_in  input  128  plaintext block, {X0,X1,X2,X3}, X0 in bits 127:96.
REQ-007 SHALL have port rk_in  input  32  round key for index rk_idx, valid same cycle.
REQ-008 SHALL have port rk_idx  output  5  round-key index requested from the key store.
REQ-009 SHALL have port data_out  output  128  result block, registered.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse, data_out updated.

Function
REQ-011 SHALL hold a 128-bit state register {A,B,C,D} and a 1-bit busy flag.
REQ-012 SHALL compute round function F = A ^ L(tau(B^C^D^rk_in)); tau = four parallel S-box lookups; L(x) = x ^ (x<<<2) ^ (x<<<10) ^ (x<<<18) ^ (x<<<24).
REQ-013 SHALL, on the edge with valid_in=1 and counter==0, apply round 0 to data_in and load {B,C,D,F} into state; set busy.
REQ-014 SHALL, on each edge with valid_in=1, busy=1 and counter in 1..31, apply one round to the state register (total 32 rounds by the counter==31 edge).
REQ-015 SHALL drive rk_idx = counter[4:0] combinationally for encryption.
REQ-016 SHALL, on the edge with save_data=1 and busy=1, register data_out = {D,C,B,A} (SM4 reverse transform) and clear busy.
REQ-017 SHALL assert data_valid for exactly the cycle after the save_data edge; latency from first valid_in cycle to data_valid = 34 cycles.
REQ-018 SHALL hold data_out stable until the next completed operation.
REQ-019 SHALL, if valid_in falls before counter==32, abort: clear busy, leave data_out unchanged, no data_valid pulse.
REQ-020 SHALL ignore counter values above 32 (valid_in held after completion): no state, data_out or data_valid change.
REQ-021 SHALL treat save_data with busy=0 as a no-op.

Reset
REQ-022 SHALL, when rest=0 at a rising edge, clear state, busy, data_out and data_valid to 0; reset overrides every simultaneous event including save_data.
REQ-023 SHALL, on reset mid-operation, discard the partial result; next operation starts cleanly at counter==0.

Configuration
REQ-024 SHALL support macro SM4_DECRYPT_EN; when defined, add input port mode  1  (0 encrypt, 1 decrypt) sampled on the load edge and held for the operation.
REQ-025 SHALL, with SM4_DECRYPT_EN and latched mode=1, drive rk_idx = 31 - counter[4:0]; datapath otherwise identical.
REQ-026 SHALL, without SM4_DECRYPT_EN, have no mode port and encrypt only.

Structure
REQ-027 SHALL place ROUNDS=32, block/word widths and the L-transform rotate amounts in shared package sm4_pkg.
REQ-028 SHALL implement the 8-bit S-box as sub-module sm4_sbox (256-entry combinational ROM), instantiated four times.

Verification
REQ-029 SHALL check GB/T 32907 vector: key 0123456789abcdeffedcba9876543210 round keys driven by model, data_in 0123456789abcdeffedcba9876543210, valid_in high 33 cycles -> data_out 681edf34d206965e86b3e94f536e4246, data_valid pulse 34 cycles after start.
REQ-030 SHALL check abort: valid_in dropped at counter==17 -> no data_valid, data_out keeps previous value; immediate restart gives correct result.
REQ-031 SHALL check reset: rest=0 at counter==20 -> all outputs 0 next cycle; rest=0 coincident with save_data -> data_valid stays 0.
REQ-032 SHALL check valid_in held past completion (counter 33..40) -> single data_valid pulse, data_out stable.
REQ-033 SHALL check, with SM4_DECRYPT_EN, mode=1, data_in 681edf34d206965e86b3e94f536e4246 -> data_out 0123456789abcdeffedcba9876543210; rk_idx sequence 31..0.
REQ-034 SHALL check back-to-back operations (valid_in low one cycle between) -> two correct results, two data_valid pulses.
